bus_arb2: RTL and testbench

- Two-requester round-robin arbiter that owns the select line of the shared 16-bit 2:1 datapath mux.
- Each requester holds its request for as long as it needs the bus (a burst). The arbiter grants one requester at a time and steers that requester's data onto the shared output.
- Sits between the two bus masters (e.g. ALU writeback and load unit) and the shared register-file write bus.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/mux2_16bit.sv | 17 +
 rtl/bus_arb2.sv | 140 ++++++++++++++
 tb/tb_bus_arb2.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-requester bus arbiter.
// State encodings, default data width and a saturating counter helper.
package bus_pkg;

   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_OWN0 = 2'b01,
      ARB_OWN1 = 2'b10
   } arb_state_e;

   function automatic logic [7:0] sat_inc(
      input logic [7:0] v,
      input logic [7:0] lim
   );
      return (v >= lim) ? lim : v + 8'd1;
   endfunction

endpackage

// File: rtl/mux2_16bit.sv
// Team 16-bit 2:1 data mux.
// sel=0 passes a, sel=1 passes b.
module mux2_16bit #(
   parameter int W = 16
) (
   input  logic         sel,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   // pure select, no storage
   always_comb begin
      y = sel ? b : a;
   end

endmodule

// File: rtl/bus_arb2.sv
// Two-requester round-robin bus arbiter driving the shared 2:1 data mux.
// Define ARB_TIMEOUT_EN to enable forced hand-over after MAX_HOLD contended cycles.
module bus_arb2
   import bus_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_HOLD = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic [DATA_W-1:0] d0,
   input  logic [DATA_W-1:0] d1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              s1,
   output logic [DATA_W-1:0] o1,
   output logic              ovalid
);

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
      $error("bus_arb2: MAX_HOLD out of range 1..255");
   end

   arb_state_e state_q, state_d;
   logic       prio_q, prio_d;
   logic       s1_q, s1_d;
   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] MAX_C = 8'(MAX_HOLD);
   logic [7:0] cnt_q, cnt_d;
   logic       exp0, exp1;

   // owner has used up its contended budget
   always_comb begin
      exp0 = req1 && (cnt_q == MAX_C);
      exp1 = req0 && (cnt_q == MAX_C);
   end
`endif

   // next-state, priority pointer and registered output values
   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      s1_d    = s1_q;
      case (state_q)
         ARB_IDLE: begin
            if (req0 && req1)
               state_d = prio_q ? ARB_OWN1 : ARB_OWN0;
            else if (req0)
               state_d = ARB_OWN0;
            else if (req1)
               state_d = ARB_OWN1;
         end
         ARB_OWN0: begin
            if (!req0)
               state_d = req1 ? ARB_OWN1 : ARB_IDLE;
`ifdef ARB_TIMEOUT_EN
            else if (exp0)
               state_d = ARB_OWN1;
`endif
         end
         ARB_OWN1: begin
            if (!req1)
               state_d = req0 ? ARB_OWN0 : ARB_IDLE;
`ifdef ARB_TIMEOUT_EN
            else if (exp1)
               state_d = ARB_OWN0;
`endif
         end
         default: state_d = ARB_IDLE;
      endcase
      // entering an owner state hands the next tie to the other side
      if (state_d != state_q) begin
         if (state_d == ARB_OWN0) begin
            prio_d = 1'b1;
            s1_d   = 1'b0;
         end else if (state_d == ARB_OWN1) begin
            prio_d = 1'b0;
            s1_d   = 1'b1;
         end
      end
      gnt0_d = (state_d == ARB_OWN0);
      gnt1_d = (state_d == ARB_OWN1);
   end

`ifdef ARB_TIMEOUT_EN
   // hold counter only advances while the other side is waiting
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q)
         cnt_d = 8'd0;
      else if ((state_q == ARB_OWN0 && req1) ||
               (state_q == ARB_OWN1 && req0))
         cnt_d = sat_inc(cnt_q, MAX_C);
   end

   // hold counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= 8'd0;
      else     cnt_q <= cnt_d;
   end
`endif

   // arbiter state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         prio_q  <= 1'b0;
         s1_q    <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         s1_q    <= s1_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
      end
   end

   // a beat is live only while the owner still requests
   always_comb begin
      gnt0   = gnt0_q;
      gnt1   = gnt1_q;
      s1     = s1_q;
      ovalid = (gnt0_q & req0) | (gnt1_q & req1);
   end

   mux2_16bit #(.W(DATA_W)) u_mux (
      .sel (s1_q),
      .a   (d0),
      .b   (d1),
      .y   (o1)
   );

endmodule

// File: tb/tb_bus_arb2.sv
// Directed and randomized checks for bus_arb2.
// Build with +define+ARB_TIMEOUT_EN to exercise the forced hand-over.
module tb_bus_arb2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0;
   logic        req1 = 1'b0;
   logic [15:0] d0 = 16'h0;
   logic [15:0] d1 = 16'h0;
   logic        gnt0, gnt1, s1, ovalid;
   logic [15:0] o1;

   int total = 0;
   int bad   = 0;

   bus_arb2 dut (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0),
      .req1   (req1),
      .d0     (d0),
      .d1     (d1),
      .gnt0   (gnt0),
      .gnt1   (gnt1),
      .s1     (s1),
      .o1     (o1),
      .ovalid (ovalid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // reference model state (0 idle, 1 own0, 2 own1)
   int   m_st, m_nx, m_cnt, m_ncnt;
   logic m_prio, m_nprio, m_s1, m_ns1;
   int   g0_cnt, g1_cnt;
   logic exp_g0;

   initial begin
      // reset state
      tick();
      chk("rst_gnt0", 32'(gnt0), 0);
      chk("rst_gnt1", 32'(gnt1), 0);
      chk("rst_s1", 32'(s1), 0);
      chk("rst_ovalid", 32'(ovalid), 0);
      rst = 1'b0;

      // single requester burst
      d0 = 16'hA5A5;
      d1 = 16'h1234;
      req0 = 1'b1;
      #1;
      chk("single_pre_gnt0", 32'(gnt0), 0);
      chk("single_pre_ovalid", 32'(ovalid), 0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("single_gnt0", 32'(gnt0), 1);
         chk("single_o1", 32'(o1), 32'hA5A5);
         chk("single_ovalid", 32'(ovalid), 1);
         chk("single_s1", 32'(s1), 0);
      end
      req0 = 1'b0;
      #1;
      chk("release_ovalid", 32'(ovalid), 0);
      chk("release_gnt0_held", 32'(gnt0), 1);
      tick();
      chk("release_gnt0", 32'(gnt0), 0);

      // reset in the middle of a burst
      req0 = 1'b1;
      tick();
      chk("mid_gnt0", 32'(gnt0), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_gnt0", 32'(gnt0), 0);
      chk("midrst_ovalid", 32'(ovalid), 0);
      chk("midrst_s1", 32'(s1), 0);
      tick();
      chk("midrst_hold_gnt0", 32'(gnt0), 0);
      chk("midrst_hold_gnt1", 32'(gnt1), 0);
      rst = 1'b0;
      tick();
      chk("postrst_gnt0", 32'(gnt0), 1);

      // simultaneous first request after reset
      req0 = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0 = 1'b1;
      req1 = 1'b1;
      tick();
      chk("tie_gnt0", 32'(gnt0), 1);
      chk("tie_gnt1", 32'(gnt1), 0);
      chk("tie_o1", 32'(o1), 32'hA5A5);
      tick();
      tick();
      chk("tie_hold_gnt0", 32'(gnt0), 1);
      req0 = 1'b0;
      tick();
      chk("handoff_gnt1", 32'(gnt1), 1);
      chk("handoff_gnt0", 32'(gnt0), 0);
      chk("handoff_s1", 32'(s1), 1);
      chk("handoff_o1", 32'(o1), 32'h1234);
      chk("handoff_ovalid", 32'(ovalid), 1);
      req1 = 1'b0;
      tick();
      chk("idle_gnt1", 32'(gnt1), 0);
      chk("idle_s1_held", 32'(s1), 1);
      chk("idle_ovalid", 32'(ovalid), 0);

      // round-robin fairness: prio points at 0 after OWN1
      g0_cnt = 0;
      g1_cnt = 0;
      exp_g0 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         req0 = 1'b1;
         req1 = 1'b1;
         tick();
         chk("rr_gnt0", 32'(gnt0), 32'(exp_g0));
         chk("rr_gnt1", 32'(gnt1), 32'(!exp_g0));
         if (gnt0) g0_cnt++;
         if (gnt1) g1_cnt++;
         exp_g0 = !exp_g0;
         req0 = 1'b0;
         req1 = 1'b0;
         tick();
         chk("rr_idle", 32'({gnt0, gnt1}), 0);
      end
      chk("rr_count0", 32'(g0_cnt), 5);
      chk("rr_count1", 32'(g1_cnt), 5);

      // long hold with contention
      req0 = 1'b1;
      tick();
      chk("to_own0", 32'(gnt0), 1);
      tick();
      req1 = 1'b1;
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("to_still_own0", 32'(gnt0), 1);
      end
      tick();
      chk("to_forced_gnt1", 32'(gnt1), 1);
      chk("to_forced_gnt0", 32'(gnt0), 0);
      chk("to_forced_s1", 32'(s1), 1);
      req1 = 1'b0;
      tick();
      chk("to_regrant0", 32'(gnt0), 1);
`else
      for (int i = 0; i < 60; i++) begin
         tick();
         chk("nto_own0", 32'(gnt0), 1);
         chk("nto_gnt1", 32'(gnt1), 0);
      end
`endif
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      chk("to_idle", 32'({gnt0, gnt1}), 0);

      // randomized run against a reference model
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_st = 0;
      m_cnt = 0;
      m_prio = 1'b0;
      m_s1 = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         if ($urandom_range(3) == 0) req0 = !req0;
         if ($urandom_range(3) == 0) req1 = !req1;
         d0 = 16'($urandom);
         d1 = 16'($urandom);
         #1;
         chk("rnd_excl", 32'(gnt0 & gnt1), 0);
         chk("rnd_gnt", 32'({gnt1, gnt0}), 32'(m_st));
         chk("rnd_s1", 32'(s1), 32'(m_s1));
         chk("rnd_ovalid", 32'(ovalid),
             32'((m_st == 1 && req0) || (m_st == 2 && req1)));
         chk("rnd_o1", 32'(o1), 32'(m_s1 ? d1 : d0));
         m_nx = m_st;
         if (m_st == 0) begin
            if (req0 && req1) m_nx = m_prio ? 2 : 1;
            else if (req0) m_nx = 1;
            else if (req1) m_nx = 2;
         end else if (m_st == 1) begin
            if (!req0) m_nx = req1 ? 2 : 0;
`ifdef ARB_TIMEOUT_EN
            else if (req1 && m_cnt == 8) m_nx = 2;
`endif
         end else begin
            if (!req1) m_nx = req0 ? 1 : 0;
`ifdef ARB_TIMEOUT_EN
            else if (req0 && m_cnt == 8) m_nx = 1;
`endif
         end
         m_ncnt = m_cnt;
         m_nprio = m_prio;
         m_ns1 = m_s1;
         if (m_nx != m_st) begin
            m_ncnt = 0;
            if (m_nx == 1) begin m_nprio = 1'b1; m_ns1 = 1'b0; end
            if (m_nx == 2) begin m_nprio = 1'b0; m_ns1 = 1'b1; end
         end else if ((m_st == 1 && req1) || (m_st == 2 && req0)) begin
            if (m_cnt < 8) m_ncnt = m_cnt + 1;
         end
         tick();
         m_st = m_nx;
         m_cnt = m_ncnt;
         m_prio = m_nprio;
         m_s1 = m_ns1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
